// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one data_ram between a core (m0) and a loader/DMA engine (m1)
//   clk, rst                       clock, synchronous active-high reset
//   mN_req/we/addr/wdata           requester N transaction, req held until mN_ack
//   mN_ack                         one-cycle pulse while mN's transaction drives the RAM
//   mN_rdata/mN_rvalid             registered read data, rvalid pulses one cycle after ack
//   ram_data/ram_addr/ram_we       data_ram pins, ram_dout combinational read data
//   DATA_RAM_ARB_FIXED_PRIO_EN     when defined, m0 always wins ties instead of round-robin
module data_ram_arbiter #(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0]     m0_wdata,
    output logic                  m0_ack,
    output logic [DWIDTH-1:0]     m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0]     m1_wdata,
    output logic                  m1_ack,
    output logic [DWIDTH-1:0]     m1_rdata,
    output logic                  m1_rvalid,
    output logic [DWIDTH-1:0]     ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DWIDTH-1:0]     ram_dout
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_n;
    logic last_grant, win1, we_q, ack0_q, ack1_q;
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
    assign win1 = m1_req & ~m0_req;
`else
    assign win1 = m1_req & (~m0_req | ~last_grant);
`endif
    // reset is honoured within the cycle it is raised so an in-flight write never commits
    assign ram_we = we_q & ~rst;
    assign m0_ack = ack0_q & ~rst;
    assign m1_ack = ack1_q & ~rst;
    always_comb begin
        state_n = (state == IDLE && (m0_req || m1_req)) ? ACCESS : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            last_grant <= 1'b1;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (state == IDLE) begin
                if (state_n == ACCESS) begin
                    we_q       <= win1 ? m1_we : m0_we;
                    ram_addr   <= win1 ? m1_addr : m0_addr;
                    ram_data   <= win1 ? m1_wdata : m0_wdata;
                    ack0_q     <= ~win1;
                    ack1_q     <= win1;
                    last_grant <= win1;
                end
            end else begin
                we_q     <= 1'b0;
                ram_data <= '0;
                ack0_q   <= 1'b0;
                ack1_q   <= 1'b0;
                if (!we_q && ack0_q) begin
                    m0_rdata  <= ram_dout;
                    m0_rvalid <= 1'b1;
                end
                if (!we_q && ack1_q) begin
                    m1_rdata  <= ram_dout;
                    m1_rvalid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: randomized and directed checks of data_ram_arbiter against a transaction model
module tb_data_ram_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic m0_ack, m0_rvalid, m1_ack, m1_rvalid, ram_we;
    logic [15:0] m0_rdata, m1_rdata, ram_data, ram_addr, ram_dout;
    bit [15:0] mem [0:65535];
    bit [15:0] ref_mem [0:65535];
    int passed = 0, total = 0;
    // model: expected outputs for the current cycle plus the transaction being executed
    logic e_ack0, e_ack1, e_rv0, e_rv1, e_we;
    logic [15:0] e_rd0, e_rd1, e_addr, e_data;
    logic last_m, t_we;
    logic [15:0] t_addr, t_data;

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    assign ram_dout = ram_we ? 16'h0 : mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // advance the model across the coming posedge, then compare at the following negedge
    task automatic step();
        logic w;
        if (rst) begin
            {e_ack0, e_ack1, e_rv0, e_rv1, e_we} = '0;
            {e_rd0, e_rd1, e_addr, e_data} = '0;
            last_m = 1'b1;
        end else begin
            e_rv0 = 1'b0;
            e_rv1 = 1'b0;
            if (e_ack0 || e_ack1) begin
                if (t_we) ref_mem[t_addr] = t_data;
                else if (e_ack0) begin e_rv0 = 1'b1; e_rd0 = ref_mem[t_addr]; end
                else begin e_rv1 = 1'b1; e_rd1 = ref_mem[t_addr]; end
                {e_ack0, e_ack1, e_we} = '0;
                e_data = '0;
            end else if (m0_req || m1_req) begin
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
                w = (m0_req && m1_req) ? 1'b0 : m1_req;
`else
                w = (m0_req && m1_req) ? !last_m : m1_req;
`endif
                last_m = w;
                t_we = w ? m1_we : m0_we;
                t_addr = w ? m1_addr : m0_addr;
                t_data = w ? m1_wdata : m0_wdata;
                e_ack0 = !w;
                e_ack1 = w;
                e_we = t_we;
                e_addr = t_addr;
                e_data = t_data;
            end
        end
        @(negedge clk);
        check("m0_ack", 16'(m0_ack), 16'(e_ack0));
        check("m1_ack", 16'(m1_ack), 16'(e_ack1));
        check("m0_rvalid", 16'(m0_rvalid), 16'(e_rv0));
        check("m1_rvalid", 16'(m1_rvalid), 16'(e_rv1));
        check("m0_rdata", m0_rdata, e_rd0);
        check("m1_rdata", m1_rdata, e_rd1);
        check("ram_we", 16'(ram_we), 16'(e_we));
        check("ram_addr", ram_addr, e_addr);
        check("ram_data", ram_data, e_data);
    endtask

    task automatic set0(input logic we, input logic [15:0] a, input logic [15:0] d);
        m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask
    task automatic set1(input logic we, input logic [15:0] a, input logic [15:0] d);
        m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    // run until every raised request is acked, then let read data drain
    task automatic drain();
        int n = 0;
        while ((m0_req || m1_req) && n < 20) begin
            step();
            if (m0_ack) m0_req = 0;
            if (m1_ack) m1_req = 0;
            n++;
        end
        if (m0_req || m1_req) check("req_timeout", 16'(m0_req | m1_req), 16'h0);
        step();
        step();
    endtask

    initial begin
        int a0 = 0, a1 = 0;
        step();
        step();
        rst = 0;
        step();
        set0(1, 16'h0010, 16'hBEEF);
        drain();
        set1(0, 16'h0010, 16'h0);
        drain();
        check("m1_read_0010", m1_rdata, 16'hBEEF);
        set0(0, 16'h0010, 16'h0);
        set1(0, 16'h0010, 16'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            a0 += int'(m0_ack);
            a1 += int'(m1_ack);
        end
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
        check("hold_m0_acks", 16'(a0), 16'd4);
        check("hold_m1_acks", 16'(a1), 16'd0);
`else
        check("hold_m0_acks", 16'(a0), 16'd2);
        check("hold_m1_acks", 16'(a1), 16'd2);
`endif
        drain();
        set0(1, 16'h0020, 16'h1234);
        set1(1, 16'h0020, 16'h5678);
        drain();
        set0(0, 16'h0020, 16'h0);
        drain();
        check("m0_read_0020", m0_rdata, 16'h5678);
        set1(1, 16'h0030, 16'hAAAA);
        step();
        check("abort_ack_seen", 16'(m1_ack), 16'h1);
        rst = 1;
        m1_req = 0;
        step();
        rst = 0;
        step();
        set0(0, 16'h0030, 16'h0);
        drain();
        check("m0_read_0030", m0_rdata, 16'h0000);
        repeat (10) step();
        for (int i = 0; i < 400; i++) begin
            if (m0_req ? m0_ack : ($urandom_range(0, 2) == 0))
                if ($urandom_range(0, 1) == 0 && m0_req) m0_req = 0;
                else set0(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
            if (m1_req ? m1_ack : ($urandom_range(0, 2) == 0))
                if ($urandom_range(0, 1) == 0 && m1_req) m1_req = 0;
                else set1(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
            step();
        end
        m0_req = 0;
        m1_req = 0;
        step();
        step();
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-port arbiter that shares a single data_ram instance between requester m0 (processor core) and requester m1 (loader/DMA engine).
- Uses a per-requester req/ack handshake and a 2-state FSM.
- Drives the RAM data/addr/we pins and returns registered read data with an rvalid pulse.
- Sits between the core/loader and data_ram; data_ram stays unmodified.

Parameters:
- DWIDTH, 16, data word width; must match data_ram DWIDTH.
- ADDR_WIDTH, 16, address width; must match data_ram ADDR_WIDTH.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  m0 request; held high until m0_ack is seen.
- m0_we  input  1  m0 write (1) / read (0); stable while m0_req=1.
- m0_addr  input  ADDR_WIDTH  m0 address.
- m0_wdata  input  DWIDTH  m0 write data.
- m0_ack  output  1  one-cycle pulse: m0 request accepted and executing.
- m0_rdata  output  DWIDTH  m0 read data; valid when m0_rvalid=1.
- m0_rvalid  output  1  one-cycle pulse, reads only.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_rvalid: same as m0, for m1.
- ram_data  output  DWIDTH  to data_ram data.
- ram_addr  output  ADDR_WIDTH  to data_ram addr.
- ram_we  output  1  to data_ram we.
- ram_dout  input  DWIDTH  from data_ram dout; combinational read, forced to 0 while we=1.

Behaviour:
- Reset values (rst=1 at a posedge): state=IDLE; all ack and rvalid outputs 0; all rdata outputs 0; ram_we=0; ram_addr=0; ram_data=0; last_grant=1, so m0 wins the first tie. Reset overrides everything, including an in-flight ACCESS. The aborted write is not committed and no ack or rvalid is issued.
- FSM states: IDLE, ACCESS.
- IDLE:
  - If m0_req or m1_req is high: select winner, latch winner's we/addr/wdata into ram_we/ram_addr/ram_data registers, set winner's ack register, go to ACCESS.
  - Otherwise stay in IDLE with ram_we=0.
- ACCESS, exactly one cycle:
  - RAM pins carry the latched transaction; winner's ackN=1.
  - On a write, data_ram commits ram_data at the ACCESS→IDLE edge.
  - On a read, ram_dout is captured into the winner's rdataN at that edge and rvalidN=1 in the following cycle.
  - Always go to IDLE. ram_we returns to 0; ram_addr holds; ram_data returns to 0.
- Latency and throughput:
  - Request sampled at edge T → ack high during cycle T+1.
  - Read data valid with rvalid during cycle T+2.
  - One transaction per 2 cycles maximum.
- Requester rules:
  - Requester drops req, or presents the next transaction, in the cycle after seeing ack.
  - req is never sampled in ACCESS, so a held req cannot be double-counted.
  - req dropped before ack is a protocol violation; behaviour is undefined and not checked.
- Round-robin arbitration:
  - Single requester: it wins.
  - Both requesting: the requester not equal to last_grant wins.
  - last_grant updates to the winner on every grant.
- rdataN holds its last value until the next read for that requester. The other requester's rdata/rvalid are unaffected.
- The two ack signals are never high together, and the two rvalid signals are never high together.
- ram_we is high only in ACCESS with a write latched.

Optional Feature:
- Macro: DATA_RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. m0 always wins when both request; last_grant is not used, and m1 can starve.
- Undefined (default): round-robin as above.

Test Plan:
- Reset then m0 write addr=0x0010 data=0xBEEF → m0_ack at T+1, ram_we=1 with ram_addr=0x0010 in that cycle; no m0_rvalid.
- After the write above, m1 read addr=0x0010 → m1_ack at T+1, m1_rvalid at T+2 with m1_rdata=0xBEEF; m0 outputs idle.
- m0 and m1 both hold read requests continuously → acks alternate m0,m1,m0,m1, one every 2 cycles, m0 first after reset; with DATA_RAM_ARB_FIXED_PRIO_EN, m0 is acked every time while m0_req stays high.
- m0 write 0x1234 to 0x0020, then m1 write 0x5678 to 0x0020 simultaneously → m0 served first; a subsequent read of 0x0020 returns 0x5678.
- rst asserted during ACCESS of an m1 write 0xAAAA to 0x0030 (mem previously 0x0000) → next cycle all outputs at reset values, no m1_ack; a read of 0x0030 returns 0x0000.
- No requests for 10 cycles → state stays IDLE; ram_we=0; all ack and rvalid outputs stay 0.
